// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer: req/ack fetch,
// next-PC selection (sequential, branch, jump), stall, halt and fetch timeout.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic [31:0] instr_i,
  output logic [31:0] instr_out_o,
  output logic        instr_valid_o,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        halt_i,
  output logic [31:0] pc_o,
  output logic        halted_o,
  output logic        fetch_error_o
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State register; reset wins over every input, including an ack mid-fetch
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        // An ack on the last counted cycle still wins over the timeout
        if (imem_ack_i) begin
          instr_d = instr_i;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (stall_i) begin
          state_d = S_EXEC;
        end else if (halt_i) begin
          state_d = S_HALT;
        end else begin
          if (jump_i)              pc_d = jump_target_i;
          else if (branch_taken_i) pc_d = branch_target_i;
          else                     pc_d = pc_q + 32'd1;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign instr_out_o   = instr_q;
  assign imem_req_o    = (state_q == S_FETCH);
  assign instr_valid_o = (state_q == S_EXEC);
  assign halted_o      = (state_q == S_HALT) || (state_q == S_ERROR);
  assign fetch_error_o = (state_q == S_ERROR);

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the processor.
- Holds the PC register and issues a request/acknowledge fetch to instruction memory.
- Presents each fetched instruction to decode/execute and selects the next PC from sequential (PC+1, word-addressed), branch or jump inputs.
- Supports stall, halt and a fetch-timeout error.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FETCH_TIMEOUT, 16, cycles FETCH may wait for IMemAck before entering ERROR (legal range 2..255)

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  leave IDLE and begin fetching at PC
IMemAddr  out  32  fetch word address; always equals PC
IMemReq  out  1  fetch request; high only in FETCH
IMemAck  in  1  memory returns Instr this cycle
Instr  in  32  instruction word from memory, valid when IMemAck=1
InstrOut  out  32  latched instruction presented to decode
InstrValid  out  1  high in every EXEC cycle
Stall  in  1  hold current instruction and PC (sampled in EXEC only)
BranchTaken  in  1  redirect to BranchTarget (EXEC only)
BranchTarget  in  32  absolute word address
Jump  in  1  redirect to JumpTarget (EXEC only)
JumpTarget  in  32  absolute word address
Halt  in  1  stop after current instruction (EXEC only)
PC  out  32  current program counter
Halted  out  1  high in HALT and ERROR
FetchError  out  1  high in ERROR

Behaviour:
- Reset (synchronous, wins over all inputs, including mid-fetch) loads:
  - State=IDLE, PC=RESET_PC, InstrOut=0, timeout counter=0.
  - All 1-bit outputs 0.
  - IMemReq drops on the edge following Reset assertion.
- All outputs are registered-state decodes; no combinational path from any input to any output except IMemAddr=PC.
- States: IDLE, FETCH, EXEC, HALT, ERROR.
- IDLE:
  - IMemReq=0. Start=1 -> FETCH. Otherwise stay.
- FETCH:
  - IMemReq=1, IMemAddr=PC.
  - IMemAck=1: InstrOut<=Instr, counter<=0, -> EXEC.
  - IMemAck=0: counter increments. When counter==FETCH_TIMEOUT-1 with no ack -> ERROR.
  - Ack on the final counted cycle is accepted (ack beats timeout).
  - IMemAck is ignored in all states other than FETCH.
- EXEC:
  - InstrValid=1. Inputs are evaluated with priority Stall > Halt > Jump > BranchTaken > sequential.
  - Stall=1: stay in EXEC; PC and InstrOut hold.
  - Halt=1: -> HALT; PC holds.
  - Jump=1: PC<=JumpTarget, -> FETCH.
  - BranchTaken=1: PC<=BranchTarget, -> FETCH.
  - Otherwise: PC<=PC+1 (32-bit unsigned, 32'hFFFF_FFFF wraps to 0), -> FETCH.
  - Jump and BranchTaken both high: Jump wins.
- HALT:
  - Halted=1, IMemReq=0, InstrValid=0. Exit only via Reset; Start is ignored.
- ERROR:
  - FetchError=1, Halted=1, IMemReq=0. Sticky until Reset.
- Latency:
  - InstrValid rises on the cycle after the IMemAck cycle.
  - Zero-wait memory gives 2 cycles per instruction (FETCH, EXEC).
- Redirect targets, Halt and Stall are only sampled in EXEC; they are don't-care elsewhere.

Test Plan:
- Reset, Start pulse, memory acks every FETCH cycle with Instr=PC, no redirects -> PC sequence 0,1,2,3; InstrOut=0,1,2,3; InstrValid high every 2nd cycle; IMemReq alternates.
- In EXEC at PC=5, assert Jump=1 (JumpTarget=40) and BranchTaken=1 (BranchTarget=20) -> next IMemAddr=40. Repeat with BranchTaken only -> 20.
- Stall high 3 cycles in EXEC at PC=7 -> InstrValid high 4 cycles, PC stays 7, no IMemReq until Stall drops, then fetch at 8.
- FETCH_TIMEOUT=4, ack withheld -> ERROR after the 4th FETCH cycle: FetchError=1, Halted=1, IMemReq=0. Ack given on the 4th cycle instead -> EXEC, no error.
- RESET_PC=32'hFFFF_FFFF, sequential step -> next fetch at 0. Halt in EXEC -> Halted=1; Start ignored; Reset returns to IDLE with PC=RESET_PC.
- Reset asserted mid-FETCH with IMemAck=1 the same cycle -> IDLE; InstrOut=0, InstrValid=0, IMemReq=0 next cycle.
